// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: commit-stage, cp0 and fetch-redirect signals of the exception controller.
// master = exc_ctrl (requesting side), slave = its environment.
`default_nettype none

interface exc_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_is_delay_slot;
  logic        m_exc_if_adel;
  logic        m_exc_ri;
  logic        m_exc_ov;
  logic        m_exc_sys;
  logic        m_exc_bp;
  logic        m_exc_adel;
  logic        m_exc_ades;
  logic [31:0] m_data_vaddr;
  logic        m_eret;
  logic [7:0]  cause_ip;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        status_exl;
  logic [31:0] epc;
  logic        exception;
  logic [4:0]  exccode;
  logic        is_delay_slot;
  logic [31:0] pc;
  logic [31:0] badvaddr;
  logic        flush;
  logic        commit_block;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    input  m_valid, m_pc, m_is_delay_slot, m_exc_if_adel, m_exc_ri, m_exc_ov,
           m_exc_sys, m_exc_bp, m_exc_adel, m_exc_ades, m_data_vaddr, m_eret,
           cause_ip, status_im, status_ie, status_exl, epc, redirect_ready,
    output exception, exccode, is_delay_slot, pc, badvaddr, flush,
           commit_block, redirect_valid, redirect_pc
  );

  modport slave (
    output m_valid, m_pc, m_is_delay_slot, m_exc_if_adel, m_exc_ri, m_exc_ov,
           m_exc_sys, m_exc_bp, m_exc_adel, m_exc_ades, m_data_vaddr, m_eret,
           cause_ip, status_im, status_ie, status_exl, epc, redirect_ready,
    input  exception, exccode, is_delay_slot, pc, badvaddr, flush,
           commit_block, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl: commit-point exception controller, cp0 request side + fetch redirect.
// Optional counters under macro EXC_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  wire logic   clk,
  input  wire logic   reset,
  exc_ctrl_if.master  bus
`ifdef EXC_STATS_EN
  ,
  output logic [31:0] exc_count,
  output logic [31:0] int_count
`endif
);

  localparam logic [4:0] c_EXC_INT  = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_ADES = 5'd5;
  localparam logic [4:0] c_EXC_SYS  = 5'd8;
  localparam logic [4:0] c_EXC_BP   = 5'd9;
  localparam logic [4:0] c_EXC_RI   = 5'd10;
  localparam logic [4:0] c_EXC_OV   = 5'd12;
  // Must match the ERET encoding cp0 decodes on its exccode input.
  localparam logic [4:0] c_EXC_ERET = 5'd14;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t      state_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic        commit_block_q;

  logic        w_int_pending;
  logic        w_any_flag;
  logic        w_is_eret;
  logic        w_take;
  logic [4:0]  w_exccode;
  logic [31:0] w_badvaddr;
  logic [31:0] redirect_pc_d;

  assign w_int_pending = bus.status_ie & ~bus.status_exl & (|(bus.cause_ip & bus.status_im));
  assign w_any_flag    = bus.m_exc_if_adel | bus.m_exc_ri | bus.m_exc_ov | bus.m_exc_sys |
                         bus.m_exc_bp | bus.m_exc_adel | bus.m_exc_ades;
  assign w_is_eret     = bus.m_eret & ~w_any_flag & ~w_int_pending;
  // Commit inputs are wrong-path while a redirect is outstanding.
  assign w_take        = ~reset & (state_q == S_IDLE) & bus.m_valid &
                         (w_any_flag | w_int_pending | bus.m_eret);
  assign redirect_pc_d = w_is_eret ? bus.epc : EXC_VECTOR;

  always_comb begin
    w_exccode  = c_EXC_INT;
    w_badvaddr = 32'd0;
    if (w_int_pending) begin
      w_exccode = c_EXC_INT;
    end else if (bus.m_exc_if_adel) begin
      w_exccode  = c_EXC_ADEL;
      w_badvaddr = bus.m_pc;
    end else if (bus.m_exc_ri) begin
      w_exccode = c_EXC_RI;
    end else if (bus.m_exc_ov) begin
      w_exccode = c_EXC_OV;
    end else if (bus.m_exc_sys) begin
      w_exccode = c_EXC_SYS;
    end else if (bus.m_exc_bp) begin
      w_exccode = c_EXC_BP;
    end else if (bus.m_exc_adel) begin
      w_exccode  = c_EXC_ADEL;
      w_badvaddr = bus.m_data_vaddr;
    end else if (bus.m_exc_ades) begin
      w_exccode  = c_EXC_ADES;
      w_badvaddr = bus.m_data_vaddr;
    end else if (bus.m_eret) begin
      w_exccode = c_EXC_ERET;
    end
  end

  assign bus.exception      = w_take;
  assign bus.flush          = w_take;
  assign bus.exccode        = w_exccode;
  assign bus.badvaddr       = w_badvaddr;
  assign bus.pc             = bus.m_pc;
  assign bus.is_delay_slot  = bus.m_is_delay_slot;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.commit_block   = commit_block_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      commit_block_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_take) begin
            state_q          <= S_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= redirect_pc_d;
            commit_block_q   <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (bus.redirect_ready) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            commit_block_q   <= 1'b0;
          end
        end
        default: begin
          state_q          <= S_IDLE;
          redirect_valid_q <= 1'b0;
          commit_block_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_count <= 32'd0;
      int_count <= 32'd0;
    end else if (w_take) begin
      exc_count <= exc_count + 32'd1;
      if (w_int_pending) begin
        int_count <= int_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scoreboard bench for exc_ctrl.
`default_nettype none

module tb_exc_ctrl;
  localparam logic [31:0] c_VEC  = 32'hBFC00380;
  localparam logic [4:0]  c_ERET = 5'd14;

  logic clk;
  logic reset;
  exc_ctrl_if bus ();

`ifdef EXC_STATS_EN
  logic [31:0] exc_count;
  logic [31:0] int_count;
`endif

  exc_ctrl #(.EXC_VECTOR(c_VEC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef EXC_STATS_EN
    ,
    .exc_count (exc_count),
    .int_count (int_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $display("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        $error("miscompare on %s", e.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    bus.m_valid = 1'b0;         bus.m_pc = 32'd0;          bus.m_is_delay_slot = 1'b0;
    bus.m_exc_if_adel = 1'b0;   bus.m_exc_ri = 1'b0;       bus.m_exc_ov = 1'b0;
    bus.m_exc_sys = 1'b0;       bus.m_exc_bp = 1'b0;       bus.m_exc_adel = 1'b0;
    bus.m_exc_ades = 1'b0;      bus.m_data_vaddr = 32'd0;  bus.m_eret = 1'b0;
    bus.cause_ip = 8'd0;        bus.status_im = 8'd0;      bus.status_ie = 1'b0;
    bus.status_exl = 1'b0;
  endtask

  task automatic exp_comb(input logic [4:0] code, input logic [31:0] bva);
    push("exception", 32'd1);
    push("flush", 32'd1);
    push("exccode", {27'd0, code});
    push("badvaddr", bva);
  endtask

  task automatic chk_comb();
    pop_check({31'd0, bus.exception});
    pop_check({31'd0, bus.flush});
    pop_check({27'd0, bus.exccode});
    pop_check(bus.badvaddr);
  endtask

  task automatic exp_quiet();
    push("exception_quiet", 32'd0);
    push("flush_quiet", 32'd0);
  endtask

  task automatic chk_quiet();
    pop_check({31'd0, bus.exception});
    pop_check({31'd0, bus.flush});
  endtask

  task automatic exp_redir(input logic rv, input logic [31:0] rpc, input logic cb);
    push("redirect_valid", {31'd0, rv});
    push("redirect_pc", rpc);
    push("commit_block", {31'd0, cb});
  endtask

  task automatic chk_redir();
    pop_check({31'd0, bus.redirect_valid});
    pop_check(bus.redirect_pc);
    pop_check({31'd0, bus.commit_block});
  endtask

  // Completes an outstanding redirect; commit inputs are left as they are.
  task automatic finish_redirect();
    bus.redirect_ready = 1'b1;
    settle();
    exp_quiet();
    chk_quiet();
    tick();
    push("redirect_valid_done", 32'd0);
    push("commit_block_done", 32'd0);
    pop_check({31'd0, bus.redirect_valid});
    pop_check({31'd0, bus.commit_block});
    bus.redirect_ready = 1'b0;
  endtask

  task automatic take_and_return(input logic [4:0] code, input logic [31:0] bva,
                                 input logic [31:0] rpc);
    settle();
    exp_comb(code, bva);
    chk_comb();
    tick();
    clear_in();
    exp_redir(1'b1, rpc, 1'b1);
    chk_redir();
    finish_redirect();
  endtask

  initial begin
    reset = 1'b1;
    bus.redirect_ready = 1'b0;
    bus.epc = 32'd0;
    clear_in();
    bus.m_valid = 1'b1;
    bus.m_exc_sys = 1'b1;
    repeat (2) tick();
    exp_quiet();
    chk_quiet();
    exp_redir(1'b0, 32'd0, 1'b0);
    chk_redir();
`ifdef EXC_STATS_EN
    push("exc_count_reset", 32'd0);
    pop_check(exc_count);
`endif
    reset = 1'b0;
    clear_in();
    tick();

    // Ov beats data AdES; the wrong-path inputs stay asserted through REDIRECT.
    bus.m_valid = 1'b1; bus.m_pc = 32'h8000_0100;
    bus.m_exc_ov = 1'b1; bus.m_exc_ades = 1'b1; bus.m_data_vaddr = 32'h1234_5679;
    settle();
    exp_comb(5'd12, 32'd0);
    chk_comb();
    tick();
    exp_redir(1'b1, c_VEC, 1'b1);
    chk_redir();
    settle();
    exp_quiet();
    chk_quiet();
    finish_redirect();
    settle();
    exp_comb(5'd12, 32'd0);
    chk_comb();
    clear_in();
    tick();

    // Interrupt: masked by m_valid=0, by a mismatched mask, then wins over RI.
    bus.status_ie = 1'b1; bus.status_im = 8'h80; bus.cause_ip = 8'h40; bus.m_valid = 1'b1;
    settle();
    exp_quiet();
    chk_quiet();
    bus.cause_ip = 8'h80; bus.m_valid = 1'b0; bus.m_exc_ri = 1'b1;
    settle();
    exp_quiet();
    chk_quiet();
    bus.m_valid = 1'b1;
    take_and_return(5'd0, 32'd0, c_VEC);

    // EXL blocks the interrupt, RI still goes to the vector.
    bus.status_ie = 1'b1; bus.status_exl = 1'b1; bus.status_im = 8'h80; bus.cause_ip = 8'h80;
    bus.m_valid = 1'b1; bus.m_exc_ri = 1'b1;
    take_and_return(5'd10, 32'd0, c_VEC);

    // ERET redirects to EPC.
    bus.epc = 32'h8000_2004;
    bus.m_valid = 1'b1; bus.m_eret = 1'b1;
    take_and_return(c_ERET, 32'd0, 32'h8000_2004);

    // ERET with fetch AdEL raises AdEL; redirect held while ready is low.
    bus.m_valid = 1'b1; bus.m_eret = 1'b1; bus.m_exc_if_adel = 1'b1;
    bus.m_pc = 32'h8000_0002; bus.m_is_delay_slot = 1'b1;
    settle();
    exp_comb(5'd4, 32'h8000_0002);
    chk_comb();
    push("pc", 32'h8000_0002);
    pop_check(bus.pc);
    push("is_delay_slot", 32'd1);
    pop_check({31'd0, bus.is_delay_slot});
    tick();
    clear_in();
    bus.m_valid = 1'b1; bus.m_exc_sys = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      exp_redir(1'b1, c_VEC, 1'b1);
      chk_redir();
      exp_quiet();
      chk_quiet();
      tick();
    end
    finish_redirect();
    settle();
    exp_comb(5'd8, 32'd0);
    chk_comb();
    clear_in();
    tick();

    // Earliest handshake: ready already high on the flush cycle.
    bus.redirect_ready = 1'b1;
    bus.m_valid = 1'b1; bus.m_exc_bp = 1'b1; bus.m_exc_adel = 1'b1;
    bus.m_data_vaddr = 32'h0040_0003;
    settle();
    exp_comb(5'd9, 32'd0);
    chk_comb();
    tick();
    clear_in();
    push("redirect_valid_early", 32'd1);
    pop_check({31'd0, bus.redirect_valid});
    tick();
    push("redirect_valid_early_done", 32'd0);
    pop_check({31'd0, bus.redirect_valid});
    bus.redirect_ready = 1'b0;

    // Data address errors carry the data address; Sys beats Bp.
    bus.m_valid = 1'b1; bus.m_exc_adel = 1'b1; bus.m_exc_ades = 1'b1;
    bus.m_data_vaddr = 32'h1000_0001;
    take_and_return(5'd4, 32'h1000_0001, c_VEC);
    bus.m_valid = 1'b1; bus.m_exc_ades = 1'b1; bus.m_data_vaddr = 32'h2000_0002;
    take_and_return(5'd5, 32'h2000_0002, c_VEC);
    bus.m_valid = 1'b1; bus.m_exc_sys = 1'b1; bus.m_exc_bp = 1'b1;
    take_and_return(5'd8, 32'd0, c_VEC);

    // Reset while a redirect is pending.
    bus.m_valid = 1'b1; bus.m_exc_sys = 1'b1;
    tick();
    clear_in();
    exp_redir(1'b1, c_VEC, 1'b1);
    chk_redir();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_redir(1'b0, 32'd0, 1'b0);
    chk_redir();

    // Back in IDLE: interrupt, Sys, ERET.
    bus.status_ie = 1'b1; bus.status_im = 8'h01; bus.cause_ip = 8'h01; bus.m_valid = 1'b1;
    take_and_return(5'd0, 32'd0, c_VEC);
    bus.m_valid = 1'b1; bus.m_exc_sys = 1'b1;
    take_and_return(5'd8, 32'd0, c_VEC);
    bus.epc = 32'h8000_3000;
    bus.m_valid = 1'b1; bus.m_eret = 1'b1;
    take_and_return(c_ERET, 32'd0, 32'h8000_3000);
`ifdef EXC_STATS_EN
    push("exc_count", 32'd3);
    pop_check(exc_count);
    push("int_count", 32'd1);
    pop_check(int_count);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Commit-point exception controller; the requesting side of the cp0 exception interface.
- Collects per-instruction exception flags from the MEM/WB boundary.
- Samples the interrupt-enable state that cp0 exports.
- Resolves priority and drives cp0's exception, exccode, pc, is_delay_slot and badvaddr inputs.
- Flushes younger pipeline stages and issues a held PC redirect (exception vector or EPC) to fetch through a valid/ready handshake.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry PC (BEV=1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_valid  in  1  committing instruction present
m_pc  in  32  PC of committing instruction
m_is_delay_slot  in  1  instruction is in a branch delay slot
m_exc_if_adel  in  1  fetch address misaligned
m_exc_ri  in  1  reserved instruction
m_exc_ov  in  1  arithmetic overflow
m_exc_sys  in  1  syscall
m_exc_bp  in  1  break
m_exc_adel  in  1  load address error
m_exc_ades  in  1  store address error
m_data_vaddr  in  32  load/store virtual address
m_eret  in  1  instruction is ERET
cause_ip  in  8  from cp0
status_im  in  8  from cp0
status_ie  in  1  from cp0
status_exl  in  1  from cp0
epc  in  32  from cp0
exception  out  1  to cp0
exccode  out  5  to cp0
is_delay_slot  out  1  to cp0
pc  out  32  to cp0
badvaddr  out  32  to cp0
flush  out  1  kill all stages younger than commit
commit_block  out  1  hold commit stage while redirect pending
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Exccode values come from the `EXC_* and `ERET macros in cp0.vh: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- int_pending = status_ie & ~status_exl & |(cause_ip & status_im). It is combinational and is only taken on a cycle with m_valid=1.
- Priority, highest first:
  - Int
  - IF AdEL (badvaddr=m_pc)
  - RI
  - Ov
  - Sys
  - Bp
  - data AdEL (badvaddr=m_data_vaddr)
  - data AdES (badvaddr=m_data_vaddr)
  - ERET (exccode=`ERET)
- ERET only when no real exception is flagged. An ERET carrying IF AdEL raises AdEL.
- badvaddr is 0 unless exccode is AdEL/AdES.
- State IDLE:
  - All to-cp0 outputs are combinational from the commit inputs, zero-latency, so cp0 latches them on the same edge.
  - pc=m_pc and is_delay_slot=m_is_delay_slot pass through. EPC adjustment is done in cp0, not here.
  - exception = m_valid & (any flag | int_pending | m_eret).
  - When exception=1: flush=1 in that cycle. Next state is REDIRECT with redirect_valid=1 registered.
  - redirect_pc = `ERET case ? epc (sampled this cycle) : EXC_VECTOR.
  - Exceptions taken with status_exl=1 still flush and redirect to EXC_VECTOR.
- State REDIRECT:
  - exception=0, flush=0, commit_block=1.
  - Commit inputs are ignored (wrong path).
  - redirect_valid and redirect_pc are held stable until redirect_ready=1. On that edge: redirect_valid drops and the state returns to IDLE.
  - The earliest handshake is 1 cycle after the flush.
  - A new exception is never accepted on the handshake cycle; the first candidate is the cycle after return to IDLE.
- Reset, including mid-REDIRECT:
  - State IDLE.
  - redirect_valid=0, redirect_pc=0, flush=0, commit_block=0.
  - exception=0 while reset=1.
- m_valid=0 never raises an exception, even with int_pending=1; the interrupt waits for the next valid instruction.

Optional Feature:
EXC_STATS_EN:
- When defined: adds outputs exc_count[31:0] and int_count[31:0]. exc_count increments on every accepted exception including ERET; int_count increments on interrupts only. Both reset to 0 and wrap at 2^32.
- When undefined: the ports are absent and no counter logic exists.

Test Plan:
- m_valid=1, m_pc=0x8000_0100, m_exc_ov=1 and m_exc_ades=1 -> exccode=12, badvaddr=0, flush=1 same cycle. Next cycle redirect_valid=1, redirect_pc=0xBFC00380.
- status_ie=1, exl=0, im=0x80, ip=0x80, m_valid=1, m_exc_ri=1 -> exccode=0 (Int wins). With m_valid=0 -> exception=0.
- m_eret=1, epc=0x8000_2004 -> exccode=`ERET, redirect_pc=0x8000_2004. m_eret=1 with m_exc_if_adel=1 and m_pc=0x8000_0002 -> exccode=4, badvaddr=0x8000_0002.
- redirect_ready held 0 for 3 cycles after exception -> redirect_valid/redirect_pc stable, commit_block=1, new m_exc_sys ignored. ready=1 -> IDLE next cycle.
- Reset asserted during REDIRECT -> next cycle redirect_valid=0, commit_block=0, state IDLE.
- EXC_STATS_EN: 3 exceptions (1 interrupt, 1 Sys, 1 ERET) -> exc_count=3, int_count=1.
